imm_gen_stage: RTL and testbench

Registered, parametrised immediate-generation pipeline stage for the decode path. It accepts one 32-bit instruction per cycle over a valid/ready handshake and classifies the format (I/S/B/U/J/none). It produces the XLEN-wide sign-extended immediate one cycle later. A 2-entry skid buffer gives full throughput under backpressure, and a flush input kills in-flight entries on branch mispredict.

---
 rtl/imm_gen_pkg.sv | 25 ++
 rtl/imm_gen_stage_decode.sv | 38 +++
 rtl/imm_gen_stage.sv | 75 +++++++
 tb/tb_imm_gen_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared format codes, opcodes and stored-entry layout for the immediate stage.
package imm_gen_pkg;

    typedef enum logic [2:0] {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} imm_fmt_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // imm is sized for the widest legal XLEN; narrower stages use the low bits
    typedef struct packed {
        logic [63:0] imm;
        imm_fmt_t    fmt;
        logic        illegal;
    } imm_entry_t;

    localparam imm_entry_t ENTRY_RST = '{imm: 64'd0, fmt: FMT_NONE, illegal: 1'b0};

endpackage

// File: rtl/imm_gen_stage_decode.sv
// imm_decode: combinational instruction-to-immediate mapping with format classification.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_t        fmt,
    output logic            illegal
);
    logic [6:0] op;
    logic [2:0] f3;
    logic       shift;
    logic [5:0] shamt;

    assign op      = instr[6:0];
    assign f3      = instr[14:12];
    assign shift   = (op == OP_IMM || op == OP_IMM32) && (f3 == 3'b001 || f3 == 3'b101);
    // RV64 OP-IMM shifts take a 6-bit shamt; word shifts and RV32 take 5 bits
    assign shamt   = (XLEN == 64 && op == OP_IMM) ? instr[25:20] : {1'b0, instr[24:20]};
    assign illegal = fmt == FMT_NONE;

    always_comb begin
        fmt = (op == OP_LOAD || op == OP_IMM || op == OP_IMM32 || op == OP_JALR) ? FMT_I :
              (op == OP_STORE)                  ? FMT_S :
              (op == OP_BRANCH)                 ? FMT_B :
              (op == OP_LUI || op == OP_AUIPC)  ? FMT_U :
              (op == OP_JAL)                    ? FMT_J : FMT_NONE;
        imm = shift           ? XLEN'(shamt) :
              (fmt == FMT_I)  ? XLEN'($signed(instr[31:20])) :
              (fmt == FMT_S)  ? XLEN'($signed({instr[31:25], instr[11:7]})) :
              (fmt == FMT_B)  ? XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})) :
              (fmt == FMT_U)  ? XLEN'($signed({instr[31:12], 12'b0})) :
              (fmt == FMT_J)  ? XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})) :
                                '0;
    end
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate generator with a 2-entry skid buffer and flush.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);
    logic [XLEN-1:0]  dec_imm;
    imm_fmt_t         dec_fmt;
    logic             dec_illegal;
    imm_entry_t       dec_e, out_e, skid_e;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_valid, accept, xfer;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    assign dec_e       = '{imm: 64'(dec_imm), fmt: dec_fmt, illegal: dec_illegal};
    assign in_ready    = !skid_valid && !rst;
    assign accept      = in_valid && in_ready;
    assign xfer        = out_valid && out_ready;
    assign out_imm     = out_e.imm[XLEN-1:0];
    assign out_fmt     = out_e.fmt;
    assign out_illegal = out_e.illegal;

    // in_ready is low whenever the skid holds data, so accept and a skid drain never coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_e      <= ENTRY_RST;
            skid_e     <= ENTRY_RST;
            out_tag    <= '0;
            skid_tag   <= '0;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || xfer) begin
            if (skid_valid) begin
                out_e      <= skid_e;
                out_tag    <= skid_tag;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_e     <= dec_e;
                out_tag   <= in_tag;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_e     <= dec_e;
            skid_tag   <= in_tag;
            skid_valid <= 1'b1;
        end
    end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed checks of decode, handshake, backpressure, flush and reset.
module tb_imm_gen_stage;
    import imm_gen_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'h0;
    logic [7:0]  in_tag = 8'h0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid, out_illegal;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic [7:0]  out_tag;
    logic        r32_in_ready, r32_out_valid, r32_out_illegal;
    logic [31:0] r32_out_imm;
    logic [2:0]  r32_out_fmt;
    logic [7:0]  r32_out_tag;

    int n_vec = 0;
    int n_err = 0;
    int exp_tag;
    int n_xfer;
    int nxt;

    always #5 clk = ~clk;

    imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(r32_in_ready),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(r32_out_valid), .out_ready(out_ready),
        .out_imm(r32_out_imm), .out_fmt(r32_out_fmt), .out_illegal(r32_out_illegal), .out_tag(r32_out_tag)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string name, input logic [31:0] instr, input logic [7:0] tag,
                       input logic [63:0] imm, input imm_fmt_t fmt, input logic ill);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        tick();
        chk({name, ".valid"}, 64'(out_valid), 64'd1);
        chk({name, ".imm"}, out_imm, imm);
        chk({name, ".fmt"}, 64'(out_fmt), 64'(fmt));
        chk({name, ".ill"}, 64'(out_illegal), 64'(ill));
        chk({name, ".tag"}, 64'(out_tag), 64'(tag));
    endtask

    initial begin
        tick();
        tick();
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.imm", out_imm, 64'd0);
        chk("rst.fmt", 64'(out_fmt), 64'(FMT_NONE));
        chk("rst.ill", 64'(out_illegal), 64'd0);
        chk("rst.tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", 64'(in_ready), 64'd1);

        // back-to-back decode vectors, one result per cycle
        vec("addi", 32'hFFF00093, 8'h01, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, 1'b0);
        vec("sd",   32'hFE20BC23, 8'h02, 64'hFFFF_FFFF_FFFF_FFF8, FMT_S, 1'b0);
        vec("beq",  32'hFE000EE3, 8'h03, 64'hFFFF_FFFF_FFFF_FFFC, FMT_B, 1'b0);
        vec("jal",  32'hFF9FF06F, 8'h04, 64'hFFFF_FFFF_FFFF_FFF8, FMT_J, 1'b0);
        vec("lui",  32'h800002B7, 8'h05, 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0);
        chk("lui32.imm", 64'(r32_out_imm), 64'h8000_0000);
        vec("slli", 32'h03F09093, 8'h06, 64'd63, FMT_I, 1'b0);
        chk("slli32.imm", 64'(r32_out_imm), 64'd31);
        vec("slliw", 32'h03F0909B, 8'h07, 64'd31, FMT_I, 1'b0);
        vec("auipc", 32'h12345017, 8'h08, 64'h0000_0000_1234_5000, FMT_U, 1'b0);
        vec("jalr", 32'h00008067, 8'h09, 64'd0, FMT_I, 1'b0);
        vec("illegal", 32'h0000007F, 8'h0A, 64'd0, FMT_NONE, 1'b1);
        in_valid = 1'b0;
        tick();
        chk("drain.out_valid", 64'(out_valid), 64'd0);

        // backpressure: out_ready low for cycles 1..3 while streaming tags 1..6
        exp_tag = 1;
        n_xfer  = 0;
        nxt     = 1;
        for (int c = 0; c < 10; c++) begin
            out_ready = !(c >= 1 && c <= 3);
            in_valid  = nxt <= 6;
            in_tag    = 8'(nxt);
            in_instr  = 32'h00000093 | (32'(nxt) << 20);
            #1;
            if (c == 1) chk("bp.in_ready_c1", 64'(in_ready), 64'd1);
            if (c == 2) chk("bp.in_ready_c2", 64'(in_ready), 64'd0);
            if (c == 4) chk("bp.in_ready_c4", 64'(in_ready), 64'd0);
            if (c >= 1) chk("bp.out_valid", 64'(out_valid), 64'd1);
            if (out_valid) begin
                chk("bp.tag", 64'(out_tag), 64'(exp_tag));
                chk("bp.imm", out_imm, 64'(exp_tag));
            end
            if (out_valid && out_ready) begin
                exp_tag++;
                n_xfer++;
            end
            if (in_valid && in_ready) nxt++;
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("bp.count", 64'(n_xfer), 64'd6);
        chk("bp.empty", 64'(out_valid), 64'd0);

        // flush with output and skid both full, plus an offered entry
        out_ready = 1'b0;
        vec("fl.a", 32'h00100093, 8'h21, 64'd1, FMT_I, 1'b0);
        in_tag = 8'h22;
        tick();
        chk("fl.full_ready", 64'(in_ready), 64'd0);
        chk("fl.held_tag", 64'(out_tag), 64'h21);
        flush  = 1'b1;
        in_tag = 8'h23;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl.out_valid", 64'(out_valid), 64'd0);
        chk("fl.in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        vec("fl.next", 32'h00200093, 8'h24, 64'd2, FMT_I, 1'b0);
        in_valid = 1'b0;
        tick();
        chk("fl.after", 64'(out_valid), 64'd0);

        // reset mid-stream with both entries valid
        out_ready = 1'b0;
        vec("rs.a", 32'h00300093, 8'h31, 64'd3, FMT_I, 1'b0);
        in_tag = 8'h32;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rs.in_ready_now", 64'(in_ready), 64'd0);
        tick();
        chk("rs.in_ready1", 64'(in_ready), 64'd0);
        tick();
        chk("rs.out_valid", 64'(out_valid), 64'd0);
        chk("rs.imm", out_imm, 64'd0);
        chk("rs.fmt", 64'(out_fmt), 64'(FMT_NONE));
        chk("rs.ill", 64'(out_illegal), 64'd0);
        chk("rs.tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rs.in_ready_after", 64'(in_ready), 64'd1);
        vec("rs.first", 32'h800002B7, 8'h40, 64'hFFFF_FFFF_8000_0000, FMT_U, 1'b0);
        in_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
